// File: rtl/screen_buffer.sv
// Double-buffered RGB565 frame store: the renderer fills the back bank, and the
// banks swap at vertical sync once the frame is done. Scan-out reads the front bank.
module screen_buffer #(
  parameter int unsigned FRAME_WIDTH  = 256,
  parameter int unsigned FRAME_HEIGHT = 128,
  parameter int unsigned FRAME_AREA   = FRAME_WIDTH * FRAME_HEIGHT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] sbuf_data,
  input  logic [15:0] sbuf_addr,
  input  logic        sbuf_write_enable,
  input  logic        frame_done,
  output logic        render_ready,
  input  logic        vsync_in,
  input  logic [15:0] scan_addr,
  input  logic        scan_enable,
  output logic [15:0] scan_data,
  output logic        scan_valid,
  output logic        front_bank,
  output logic [15:0] drop_count
);

  localparam int unsigned AW = $clog2(FRAME_AREA);

  typedef enum logic {RENDER, PENDING} state_t;

  state_t state, state_nxt;
  logic   front_nxt;

  logic        wr_in_range, rd_in_range;
  logic        wr_commit, wr_drop;
  logic [15:0] mem [2*FRAME_AREA];
  logic [15:0] ram_q;
  logic        rd_valid_q, rd_oor_q;

  assign wr_in_range = 32'(sbuf_addr) < FRAME_AREA;
  assign rd_in_range = 32'(scan_addr) < FRAME_AREA;
  // Gated by reset so a write presented while reset is held never lands in the bank.
  assign wr_commit   = rst_in && sbuf_write_enable && wr_in_range && (state == RENDER);
  assign wr_drop     = sbuf_write_enable && wr_in_range && (state == PENDING);

  assign render_ready = (state == RENDER);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= RENDER;
      front_bank <= 1'b0;
    end else begin
      state      <= state_nxt;
      front_bank <= front_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    front_nxt = front_bank;
    case (state)
      RENDER: begin
        if (frame_done) begin
          if (vsync_in) front_nxt = ~front_bank;
          else          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (vsync_in) begin
          front_nxt = ~front_bank;
          state_nxt = RENDER;
        end
      end
      default: state_nxt = RENDER;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      drop_count <= '0;
    end else if (wr_drop && (drop_count != '1)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // Both banks share one RAM; the bank index is the top address bit.
  always_ff @(posedge clk_in) begin
    if (wr_commit) mem[{~front_bank, sbuf_addr[AW-1:0]}] <= sbuf_data;
  end

  always_ff @(posedge clk_in) begin
    if (scan_enable) ram_q <= mem[{front_bank, scan_addr[AW-1:0]}];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      scan_valid <= 1'b0;
      scan_data  <= '0;
    end else begin
      rd_valid_q <= scan_enable;
      rd_oor_q   <= ~rd_in_range;
      scan_valid <= rd_valid_q;
      if (rd_valid_q) scan_data <= rd_oor_q ? '0 : ram_q;
    end
  end

endmodule
